// File: rtl/mprj_wb_timeout_bridge.sv
// Registered Wishbone bridge from the management core's user-project bus to the user project.
// Every management access terminates: a user ack that is missing, or gated off by wb_iena_i,
// is replaced by an error ack carrying ERR_DATA after TIMEOUT_CYCLES edges in REQ.
// Timeouts set a sticky flag (cleared by to_clr_i) and bump a saturating 8-bit event counter.
//
// Ports:
//   core_clk, core_rst          clock, asynchronous active-high reset
//   m_cyc_i .. m_dat_i          master request (cyc, stb, we, sel, adr, write data)
//   m_ack_o, m_dat_o            one-cycle ack pulse and read data to the master
//   wb_iena_i                   user return enable; gates s_ack_i / s_dat_i
//   s_cyc_o .. s_dat_o          registered request toward the user project
//   s_ack_i, s_dat_i            user ack and read data
//   to_clr_i                    clears timeout_flag_o
//   timeout_flag_o              sticky timeout indicator
//   timeout_cnt_o               saturating timeout count, cleared only by reset
module mprj_wb_timeout_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  input  logic [3:0]  m_sel_i,
  input  logic [31:0] m_adr_i,
  input  logic [31:0] m_dat_i,
  output logic        m_ack_o,
  output logic [31:0] m_dat_o,
  input  logic        wb_iena_i,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  input  logic        to_clr_i,
  output logic        timeout_flag_o,
  output logic [7:0]  timeout_cnt_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  // REQ exits when the counter holds this value, so it never wraps.
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StAck, StGuard} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdat_q, rdat_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic            flag_q, flag_d;
  logic [7:0]      tcnt_q, tcnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ack_d   = 1'b0;
    rdat_d  = rdat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    // A timeout below overrides this, so a set on the clear edge wins.
    flag_d  = to_clr_i ? 1'b0 : flag_q;
    tcnt_d  = tcnt_q;

    unique case (state_q)
      StIdle: begin
        if (m_cyc_i && m_stb_i) begin
          we_d    = m_we_i;
          sel_d   = m_sel_i;
          adr_d   = m_adr_i;
          wdat_d  = m_dat_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        // Priority: valid user ack, then master abort, then timeout.
        if (s_ack_i && wb_iena_i) begin
          rdat_d  = s_dat_i;
          req_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = StAck;
        end else if (!m_cyc_i) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          rdat_d  = ERR_DATA;
          req_d   = 1'b0;
          ack_d   = 1'b1;
          flag_d  = 1'b1;
          if (tcnt_q != 8'd255) begin
            tcnt_d = tcnt_q + 8'd1;
          end
          state_d = StAck;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAck: begin
        state_d = StGuard;
      end
      StGuard: begin
        // Master releases stb during this cycle; it is not sampled here.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      flag_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      flag_q  <= flag_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign m_ack_o        = ack_q;
  assign m_dat_o        = rdat_q;
  assign s_cyc_o        = req_q;
  assign s_stb_o        = req_q;
  assign s_we_o         = we_q;
  assign s_sel_o        = sel_q;
  assign s_adr_o        = adr_q;
  assign s_dat_o        = wdat_q;
  assign timeout_flag_o = flag_q;
  assign timeout_cnt_o  = tcnt_q;

endmodule

// File: tb/tb_mprj_wb_timeout_bridge.sv
module tb_mprj_wb_timeout_bridge;

  localparam int unsigned T   = 64;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b1;
  logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
  logic [3:0]  m_sel_i = '0;
  logic [31:0] m_adr_i = '0, m_dat_i = '0;
  logic        m_ack_o;
  logic [31:0] m_dat_o;
  logic        wb_iena_i = 1'b1;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i = 1'b0;
  logic [31:0] s_dat_i = '0;
  logic        to_clr_i = 1'b0;
  logic        timeout_flag_o;
  logic [7:0]  timeout_cnt_o;

  mprj_wb_timeout_bridge #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
    .wb_iena_i(wb_iena_i),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .to_clr_i(to_clr_i), .timeout_flag_o(timeout_flag_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 core_clk = ~core_clk;

  int cyc_n = 0;
  always @(posedge core_clk) cyc_n = cyc_n + 1;

  typedef struct {
    logic [31:0] data;
    int          ack_cyc;
    logic        flag;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model state
  logic        m_flag = 1'b0;
  logic [7:0]  m_cnt  = '0;
  logic [31:0] last_dat = '0;
  logic        cur_we = 1'b0;
  logic [3:0]  cur_sel = '0;
  logic [31:0] cur_adr = '0, cur_wdat = '0;

  // Slave behaviour plan for the current access
  int          plan_d = 1000;
  logic        plan_iena = 1'b1;
  logic [31:0] plan_sdat = '0;
  logic        plan_late = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Slave: acks plan_d cycles after it first sees s_stb_o; optional late ack during ACK.
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge core_clk);
      wb_iena_i = plan_iena;
      s_dat_i   = $urandom;
      s_ack_i   = 1'b0;
      if (s_stb_o) begin
        if (k == plan_d) begin
          s_ack_i = 1'b1;
          s_dat_i = plan_sdat;
        end
        k++;
      end else begin
        k = 0;
      end
      if (plan_late && m_ack_o) s_ack_i = 1'b1;
    end
  end

  // Monitor: pops an expectation for each ack and checks bus outputs every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge core_clk);
      if (!core_rst) begin
        if (m_ack_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got m_ack_o=1 expected 0 (cycle %0d)", cyc_n);
          end else begin
            e = exp_q.pop_front();
            chk("ack_data", m_dat_o, e.data);
            chk("ack_cycle", 32'(cyc_n), 32'(e.ack_cyc));
            chk("ack_flag", 32'(timeout_flag_o), 32'(e.flag));
            chk("ack_cnt", 32'(timeout_cnt_o), 32'(e.cnt));
            last_dat = e.data;
          end
        end else begin
          chk("m_dat_hold", m_dat_o, last_dat);
        end
        if (s_stb_o) begin
          chk("s_cyc", 32'(s_cyc_o), 32'd1);
          chk("s_we", 32'(s_we_o), 32'(cur_we));
          chk("s_sel", 32'(s_sel_o), 32'(cur_sel));
          chk("s_adr", s_adr_o, cur_adr);
          chk("s_dat", s_dat_o, cur_wdat);
        end else begin
          chk("s_cyc_idle", 32'(s_cyc_o), 32'd0);
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] wdat, input int d, input logic iena,
                        input logic [31:0] sdat, input logic late, input logic clr_on_to);
    exp_t e;
    int   e0;
    bit   got;
    cur_we = we; cur_sel = sel; cur_adr = adr; cur_wdat = wdat;
    plan_d = d; plan_iena = iena; plan_sdat = sdat; plan_late = late;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_sel_i = sel;
    m_adr_i = adr; m_dat_i = wdat;
    e0 = cyc_n + 1;
    // A usable ack must arrive within the T edges REQ allows.
    if (iena && d <= int'(T) - 1) begin
      e.data    = sdat;
      e.ack_cyc = e0 + d + 1;
    end else begin
      e.data    = ERR;
      e.ack_cyc = e0 + int'(T);
      m_flag    = 1'b1;
      if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    end
    e.flag = m_flag;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    got = 0;
    for (int i = 0; i < int'(T) + 8 && !got; i++) begin
      @(negedge core_clk);
      to_clr_i = (clr_on_to && cyc_n == e0 + int'(T) - 1) ? 1'b1 : 1'b0;
      if (m_ack_o) got = 1;
    end
    to_clr_i = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: got no m_ack_o expected one within %0d cycles", T + 8);
      void'(exp_q.pop_front());
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge core_clk);
    @(negedge core_clk);
    plan_late = 1'b0;
    plan_d    = 1000;
  endtask

  task automatic clear_flag();
    to_clr_i = 1'b1;
    @(negedge core_clk);
    to_clr_i = 1'b0;
    m_flag = 1'b0;
    chk("clr_flag", 32'(timeout_flag_o), 32'd0);
    chk("clr_cnt", 32'(timeout_cnt_o), 32'(m_cnt));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_ack"}, 32'(m_ack_o), 32'd0);
    chk({tag, "_m_dat"}, m_dat_o, 32'd0);
    chk({tag, "_s_cyc"}, 32'(s_cyc_o), 32'd0);
    chk({tag, "_s_stb"}, 32'(s_stb_o), 32'd0);
    chk({tag, "_s_we"}, 32'(s_we_o), 32'd0);
    chk({tag, "_s_sel"}, 32'(s_sel_o), 32'd0);
    chk({tag, "_s_adr"}, s_adr_o, 32'd0);
    chk({tag, "_s_dat"}, s_dat_o, 32'd0);
    chk({tag, "_flag"}, 32'(timeout_flag_o), 32'd0);
    chk({tag, "_cnt"}, 32'(timeout_cnt_o), 32'd0);
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge core_clk);
    core_rst = 1'b0;
    @(negedge core_clk);

    // Zero-wait read, write with a couple of wait states
    access(1'b0, 4'hF, 32'h3000_0000, 32'h0, 0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    access(1'b1, 4'b0011, 32'h3000_0004, 32'hA5A5_A5A5, 2, 1'b1, 32'h0, 1'b0, 1'b0);
    // Timeout with a late ack afterwards, then clear
    access(1'b0, 4'hF, 32'h3000_0008, 32'h0, 1000, 1'b1, 32'h0, 1'b1, 1'b0);
    clear_flag();
    // Ack on the timeout edge wins; one edge later is too late
    access(1'b0, 4'hF, 32'h3000_000C, 32'h0, int'(T) - 1, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
    access(1'b0, 4'hF, 32'h3000_0010, 32'h0, int'(T), 1'b1, 32'hCAFE_0002, 1'b0, 1'b0);

    // Master abort in REQ
    cur_we = 1'b0; cur_sel = 4'hF; cur_adr = 32'h3000_0020; cur_wdat = '0;
    plan_d = 1000;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_sel_i = 4'hF;
    m_adr_i = 32'h3000_0020; m_dat_i = '0;
    repeat (6) @(negedge core_clk);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge core_clk);
    chk("abort_s_cyc", 32'(s_cyc_o), 32'd0);
    access(1'b0, 4'hF, 32'h3000_0024, 32'h0, 1, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Reset mid-REQ
    cur_adr = 32'h3000_0030;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h3000_0030;
    repeat (4) @(negedge core_clk);
    #2 core_rst = 1'b1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    #1;
    check_reset_outputs("midreq_rst");
    m_flag = 1'b0; m_cnt = '0; last_dat = '0;
    @(negedge core_clk);
    #1 core_rst = 1'b0;
    @(negedge core_clk);
    access(1'b1, 4'b1100, 32'h3000_0034, 32'h5555_AAAA, 0, 1'b1, 32'h7777_8888, 1'b0, 1'b0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom), 4'($urandom), $urandom, $urandom,
             int'($urandom_range(0, T + 4)), ($urandom_range(0, 4) != 0), $urandom,
             1'($urandom), 1'b0);
    end

    // Gated returns: always time out, counter saturates
    for (int i = 0; i < 300; i++) begin
      if (i == 299) clear_flag();
      access(1'b0, 4'hF, 32'h3000_0100, 32'h0, 0, 1'b0, 32'h1111_2222, 1'b0, i == 299);
    end
    chk("sat_cnt", 32'(timeout_cnt_o), 32'd255);
    chk("set_wins_flag", 32'(timeout_flag_o), 32'd1);
    clear_flag();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
